// File: rtl/regfile_apb_if.sv
// APB3 slave front-end for the register file: decodes transfers into one-cycle
// per-register write/read strobes and muxes the register flop outputs onto prdata.
module regfile_apb_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int REG_NUM    = 8,
   parameter int BASE_ADDR  = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          psel,
   input  logic                          penable,
   input  logic                          pwrite,
   input  logic [ADDR_WIDTH-1:0]         paddr,
   input  logic [DATA_WIDTH-1:0]         pwdata,
   output logic [DATA_WIDTH-1:0]         prdata,
   output logic                          pready,
   output logic                          pslverr,
   output logic [REG_NUM-1:0]            reg_wen,
   output logic [DATA_WIDTH-1:0]         reg_wdata,
   output logic [REG_NUM-1:0]            reg_ren,
   input  logic [REG_NUM*DATA_WIDTH-1:0] reg_rdata
);

   localparam int SEL_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
   localparam int CMP_W = ADDR_WIDTH + 7;
   localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [CMP_W-1:0]      NUM_C = CMP_W'(REG_NUM);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                  state_q, state_d;
   logic                    wr_q, wr_d;
   logic                    err_q, err_d;
   logic [SEL_W-1:0]        idx_q, idx_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

   logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
   logic                    pready_q, pready_d;
   logic                    pslverr_q, pslverr_d;
   logic [REG_NUM-1:0]      reg_wen_q, reg_wen_d;
   logic [REG_NUM-1:0]      reg_ren_q, reg_ren_d;
   logic [DATA_WIDTH-1:0]   reg_wdata_q, reg_wdata_d;

   // Extra MSB of the subtraction is the borrow, i.e. paddr < BASE_ADDR.
   logic [ADDR_WIDTH:0]     diff;
   logic [ADDR_WIDTH-1:0]   dec_index;
   logic                    dec_err;

   assign diff      = {1'b0, paddr} - {1'b0, BASE};
   assign dec_index = diff[ADDR_WIDTH-1:0] >> 2;
   assign dec_err   = (paddr[1:0] != 2'b00) || diff[ADDR_WIDTH] ||
                      ({7'd0, dec_index} >= NUM_C);

   logic [DATA_WIDTH-1:0]   rdata_arr [REG_NUM];
   logic [DATA_WIDTH-1:0]   rd_sel;
   logic [REG_NUM-1:0]      sel_onehot;

   genvar gi;
   generate
      for (gi = 0; gi < REG_NUM; gi++) begin : g_rd_slice
         assign rdata_arr[gi] = reg_rdata[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   always_comb begin
      rd_sel     = '0;
      sel_onehot = '0;
      for (int i = 0; i < REG_NUM; i++) begin
         if (idx_q == SEL_W'(i)) begin
            sel_onehot[i] = 1'b1;
            rd_sel        = rdata_arr[i];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      err_d       = err_q;
      idx_d       = idx_q;
      wdata_d     = wdata_q;
      prdata_d    = '0;
      pready_d    = 1'b0;
      pslverr_d   = 1'b0;
      reg_wen_d   = '0;
      reg_ren_d   = '0;
      reg_wdata_d = reg_wdata_q;
      case (state_q)
         S_IDLE: begin
            if (psel && !penable) begin
               state_d = S_WAIT;
               wr_d    = pwrite;
               wdata_d = pwdata;
               idx_d   = dec_index[SEL_W-1:0];
               err_d   = dec_err;
            end
         end
         S_WAIT: begin
            if (!psel) begin
               state_d = S_IDLE;
            end else if (penable) begin
               // Response outputs are prepared here so they are registered in RESP.
               state_d   = S_RESP;
               pready_d  = 1'b1;
               pslverr_d = err_q;
               if (!err_q) begin
                  if (wr_q) begin
                     reg_wen_d   = sel_onehot;
                     reg_wdata_d = wdata_q;
                  end else begin
                     reg_ren_d = sel_onehot;
                     prdata_d  = rd_sel;
                  end
               end
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         wr_q        <= 1'b0;
         err_q       <= 1'b0;
         idx_q       <= '0;
         wdata_q     <= '0;
         prdata_q    <= '0;
         pready_q    <= 1'b0;
         pslverr_q   <= 1'b0;
         reg_wen_q   <= '0;
         reg_ren_q   <= '0;
         reg_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_d;
         err_q       <= err_d;
         idx_q       <= idx_d;
         wdata_q     <= wdata_d;
         prdata_q    <= prdata_d;
         pready_q    <= pready_d;
         pslverr_q   <= pslverr_d;
         reg_wen_q   <= reg_wen_d;
         reg_ren_q   <= reg_ren_d;
         reg_wdata_q <= reg_wdata_d;
      end
   end

   assign prdata    = prdata_q;
   assign pready    = pready_q;
   assign pslverr   = pslverr_q;
   assign reg_wen   = reg_wen_q;
   assign reg_ren   = reg_ren_q;
   assign reg_wdata = reg_wdata_q;

endmodule

// File: tb/tb_regfile_apb_if.sv
// Self-checking bench for regfile_apb_if: table-driven APB transfers with a
// scoreboard, plus hand-written abort, reset and ignored-enable sequences.
module tb_regfile_apb_if;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int RN = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            psel = 1'b0;
   logic            penable = 1'b0;
   logic            pwrite = 1'b0;
   logic [AW-1:0]   paddr = '0;
   logic [DW-1:0]   pwdata = '0;
   logic [DW-1:0]   prdata;
   logic            pready;
   logic            pslverr;
   logic [RN-1:0]   reg_wen;
   logic [RN-1:0]   reg_ren;
   logic [DW-1:0]   reg_wdata;
   logic [RN*DW-1:0] reg_rdata;

   logic [DW-1:0]   flops  [RN];
   logic [DW-1:0]   shadow [RN];
   logic [DW-1:0]   last_wdata = '0;
   bit              loaded = 1'b0;
   int              n_chk = 0;
   int              n_bad = 0;
   int              cyc = 0;
   int              last_rdy = -100;
   int              n_xfer = 0;

   typedef struct {
      logic [DW-1:0] prdata;
      logic          slverr;
      logic [RN-1:0] wen;
      logic [RN-1:0] ren;
      logic [DW-1:0] wdata;
   } exp_t;

   typedef struct {
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      bit            err;
   } vec_t;

   exp_t sb[$];
   vec_t tbl [12];

   regfile_apb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_NUM(RN), .BASE_ADDR(0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr),
      .reg_wen   (reg_wen),
      .reg_wdata (reg_wdata),
      .reg_ren   (reg_ren),
      .reg_rdata (reg_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] init_val(int i);
      return (i == 7) ? 32'h1234_5678 : (32'hC0DE_0000 | DW'(i));
   endfunction

   // Register flop model: not reset by rst_n, so a lost write stays visible.
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < RN; i++) flops[i] <= init_val(i);
         loaded <= 1'b1;
      end else begin
         for (int i = 0; i < RN; i++) if (reg_wen[i]) flops[i] <= reg_wdata;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < RN; gi++) begin : g_flat
         assign reg_rdata[gi*DW +: DW] = flops[gi];
      end
   endgenerate

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic ok;
      ok = ($countones({reg_wen, reg_ren}) <= 1);
      check("strobe_onehot", DW'(ok), 32'd1);
   end

   task automatic xfer(input vec_t v, input bit b2b);
      exp_t e;
      int   idx;
      int   waited;
      idx      = int'(v.addr >> 2);
      e.slverr = v.err;
      e.wen    = '0;
      e.ren    = '0;
      e.prdata = '0;
      if (!v.err) begin
         if (v.wr) begin
            e.wen       = RN'(1) << idx;
            shadow[idx] = v.wdata;
            last_wdata  = v.wdata;
         end else begin
            e.ren    = RN'(1) << idx;
            e.prdata = shadow[idx];
         end
      end
      e.wdata = last_wdata;
      sb.push_back(e);

      psel = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.addr; pwdata = v.wdata;
      @(posedge clk); #1;
      check("wait_pready", DW'(pready), 32'd0);
      penable = 1'b1;
      waited = 0;
      do begin
         @(posedge clk); #1;
         waited++;
      end while (!pready && waited < 6);
      check("latency", DW'(waited), 32'd1);
      if (b2b) check("b2b_spacing", DW'(cyc - last_rdy), 32'd3);
      last_rdy = cyc;

      e = sb.pop_front();
      check("pready",    DW'(pready),  32'd1);
      check("pslverr",   DW'(pslverr), DW'(e.slverr));
      check("prdata",    prdata,       e.prdata);
      check("reg_wen",   DW'(reg_wen), DW'(e.wen));
      check("reg_ren",   DW'(reg_ren), DW'(e.ren));
      check("reg_wdata", reg_wdata,    e.wdata);
      $display("xfer %0d: %s addr=%h wdata=%h -> prdata=%h slverr=%0d wen=%h ren=%h",
               n_xfer, v.wr ? "WR" : "RD", v.addr, v.wdata, prdata, pslverr, reg_wen, reg_ren);
      n_xfer++;

      @(posedge clk); #1;
      check("strobe_clear", DW'({reg_wen, reg_ren, pready, pslverr}), 32'd0);
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic check_quiet(input string name);
      check(name, DW'({reg_wen, reg_ren, pready, pslverr}), 32'd0);
      check({name, "_prdata"}, prdata, 32'd0);
   endtask

   initial begin
      vec_t v;
      for (int i = 0; i < RN; i++) shadow[i] = init_val(i);

      tbl[0]  = '{1'b1, 8'h08, 32'hA5A5_0001, 1'b0};
      tbl[1]  = '{1'b0, 8'h1C, 32'h0,         1'b0};
      tbl[2]  = '{1'b1, 8'h20, 32'h1111_1111, 1'b1};
      tbl[3]  = '{1'b1, 8'h05, 32'h2222_2222, 1'b1};
      tbl[4]  = '{1'b0, 8'h08, 32'h0,         1'b0};
      tbl[5]  = '{1'b0, 8'h21, 32'h0,         1'b1};
      tbl[6]  = '{1'b1, 8'h1C, 32'hDEAD_BEEF, 1'b0};
      tbl[7]  = '{1'b0, 8'h1C, 32'h0,         1'b0};
      tbl[8]  = '{1'b0, 8'hFC, 32'h0,         1'b1};
      tbl[9]  = '{1'b1, 8'h00, 32'hCAFE_F00D, 1'b0};
      tbl[10] = '{1'b0, 8'h00, 32'h0,         1'b0};
      tbl[11] = '{1'b0, 8'h04, 32'h0,         1'b0};

      repeat (3) @(posedge clk);
      #1;
      check_quiet("reset_outputs");
      check("reset_wdata", reg_wdata, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check_quiet("idle_bus");
      end

      for (int i = 0; i < 12; i++) xfer(tbl[i], i > 0);

      // psel+penable without a setup phase must be ignored.
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h18; pwdata = 32'h7777_7777;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_quiet("no_setup_ignored");
      end
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;

      // Abort: psel dropped during the wait state.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'h5555_AAAA;
      @(posedge clk); #1;
      psel = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check_quiet("abort_quiet");
      end
      v = '{1'b0, 8'h10, 32'h0, 1'b0};
      xfer(v, 1'b0);
      v = '{1'b0, 8'h18, 32'h0, 1'b0};
      xfer(v, 1'b1);

      // Reset during the wait state of a write.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h1111_2222;
      @(posedge clk); #1;
      penable = 1'b1;
      rst_n = 1'b0;
      #1;
      check_quiet("reset_midxfer");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_quiet("reset_hold");
      end
      psel = 1'b0; penable = 1'b0;
      rst_n = 1'b1;
      last_wdata = '0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check_quiet("after_release");
      end
      v = '{1'b0, 8'h0C, 32'h0, 1'b0};
      xfer(v, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/regfile_apb_if.md
Name: regfile_apb_if

Overview:
APB3 slave front-end for the generated register file. Decodes bus transfers into one-cycle per-register write strobes plus shared write data that drive the reset-valued data flops of each register. Selects each register's flop output back onto the read bus. Sits directly upstream of the register flops on the write path and downstream of them on the read path.

Parameters:
ADDR_WIDTH, 8, APB address width in bits.
DATA_WIDTH, 32, register and bus data width in bits.
REG_NUM, 8, number of registers, 1..64; register i is at byte address BASE_ADDR + 4*i.
BASE_ADDR, 0, byte address of register 0; must be 4-byte aligned.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
psel  input  1  APB select.
penable  input  1  APB enable.
pwrite  input  1  1 = write, 0 = read.
paddr  input  ADDR_WIDTH  byte address.
pwdata  input  DATA_WIDTH  write data.
prdata  output  DATA_WIDTH  read data; valid when pready=1.
pready  output  1  transfer complete.
pslverr  output  1  error response; valid when pready=1.
reg_wen  output  REG_NUM  one-hot write strobe, one cycle per write.
reg_wdata  output  DATA_WIDTH  write data to the register flops.
reg_ren  output  REG_NUM  one-hot read pulse for clear-on-read side effects.
reg_rdata  input  REG_NUM*DATA_WIDTH  flattened flop outputs; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (async assert, synchronous release on clk): FSM returns to IDLE. prdata=0, pready=0, pslverr=0, reg_wen=0, reg_ren=0, reg_wdata=0. All outputs are registered.
- FSM states: IDLE, WAIT, RESP.
- IDLE: when psel=1 and penable=0 (setup phase), go to WAIT and latch the following:
  - pwrite and pwdata;
  - decoded index = (paddr - BASE_ADDR) >> 2;
  - err = paddr[1:0] != 0, or paddr < BASE_ADDR, or index >= REG_NUM.
- WAIT: pready=0 (one fixed wait state).
  - If psel=1 and penable=1: go to RESP. Registered outputs update so that in the RESP cycle pready=1 and pslverr=err.
  - If psel=0: protocol abort; return to IDLE. No strobe, no response.
- RESP, write, no err: reg_wen[index]=1 and reg_wdata=latched pwdata in this same cycle. The flop captures on the next edge. prdata=0.
- RESP, read, no err: prdata = reg_rdata slice sampled at the end of the WAIT cycle; reg_ren[index]=1 in this cycle.
- RESP, err: pslverr=1, prdata=0, no reg_wen and no reg_ren bits set.
- After RESP, all strobes return to 0 and the FSM returns to IDLE. A new setup phase is accepted in the cycle directly after RESP, so back-to-back transfers are 3 cycles each.
- Latency: setup to pready is 2 cycles. Write data is visible at the flop output 1 cycle after RESP.
- reg_wdata holds its last value outside RESP; it is meaningful only when a reg_wen bit is set.
- At most one reg_wen or reg_ren bit is ever high. reg_wen and reg_ren are never high in the same cycle.
- psel=1 with penable=1 while in IDLE (no setup phase): ignored, stay in IDLE.
- Address decode uses the full ADDR_WIDTH. Wrap-around in paddr - BASE_ADDR is caught by the paddr < BASE_ADDR check.
- Reset asserted mid-transfer: pending strobes are cancelled immediately; no partial write reaches any register.

Test Plan:
- Reset then idle bus: all outputs 0 during and after reset; pready stays 0 for 10 cycles.
- Write 0xA5A5_0001 to addr 0x08 (BASE_ADDR=0) -> pready=1 two cycles after setup; reg_wen=0x04 for exactly one cycle with reg_wdata=0xA5A5_0001; pslverr=0.
- Read addr 0x1C with reg_rdata slice 7 = 0x1234_5678 -> prdata=0x1234_5678 with pready; reg_ren=0x80 for one cycle.
- Errors: write to 0x20 (index 8 ≥ REG_NUM), then write to 0x05 (unaligned) -> each response has pready=1 and pslverr=1, reg_wen=0, prdata=0.
- Back-to-back: write addr 0x00 then read addr 0x00 with no idle cycle between them -> second pready exactly 3 cycles after the first; read returns the newly written value.
- Abort and reset: psel dropped in WAIT -> no pready, no strobe. Separately, rst_n asserted in the WAIT cycle of a write -> reg_wen never rises and the FSM is in IDLE after release.
